// File: rtl/km_modmul_ctrl.sv
// ---------------------------------------------------------------------------
// km_modmul_ctrl
//
// Purpose:
//   Sequencing controller for a modular multiplier built around an external,
//   shared Karatsuba multiplier (km_b). It takes one operand pair, drives
//   km_b, waits out its latency, and captures the 2W-bit product. It then
//   reduces the product mod Q = 2^W - C with two pseudo-Mersenne folds and
//   one conditional subtract, and returns the residue. Only one operation is
//   in flight at a time, and latency is fixed regardless of operand values.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a/in_b are any W-bit values
//   out_valid/out_ready   result handshake; out_p = (in_a*in_b) mod Q
//   mul_a/mul_b           registered operands to km_b
//   mul_start             one-cycle pulse in the first cycle mul_a/mul_b are valid
//   mul_p                 2W-bit product returned by km_b
//   busy                  high in every state except IDLE
//   dbg_state             current FSM state, for observation only
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. in_ready is high only in IDLE, so in_a/in_b are never
// sampled elsewhere. out_valid is high throughout DONE, with out_p stable. It
// drops only after an edge with out_ready high. The completing edge returns
// the FSM to IDLE, so the next accept is at least one edge later.
// ---------------------------------------------------------------------------
module km_modmul_ctrl #(
    parameter int W       = 32,
    parameter int C       = 5,
    parameter int MUL_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_p,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    output logic             mul_start,
    input  logic [2*W-1:0]   mul_p,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_FOLD1 = 3'd2;
    localparam logic [2:0] S_FOLD2 = 3'd3;
    localparam logic [2:0] S_CORR  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // The counter needs to hold the value MUL_LAT itself.
    localparam int              CW      = $clog2(MUL_LAT + 2);
    localparam logic [CW-1:0]   LAT_CNT = CW'(MUL_LAT);

    localparam logic [2*W-1:0]  C_X    = (2*W)'(C);
    localparam logic [2*W-1:0]  MASK_W = {{W{1'b0}}, {W{1'b1}}};
    localparam logic [2*W-1:0]  Q_X    = MASK_W - C_X + (2*W)'(1);
    localparam logic [W-1:0]    Q_W    = Q_X[W-1:0];

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  x_q, x_d;
    logic [W-1:0]    mul_a_q, mul_a_d;
    logic [W-1:0]    mul_b_q, mul_b_d;
    logic            mul_start_q, mul_start_d;
    logic [W-1:0]    out_p_q, out_p_d;

    // One pseudo-Mersenne fold: 2^W == C (mod Q), so hi*2^W + lo == hi*C + lo.
    // The same datapath serves both folds. The first fold leaves the high half
    // at most C, so the second fold brings x below 2^W + C*(C+1), which is < 2Q.
    logic [2*W-1:0]  fold_v;
    assign fold_v = ({{W{1'b0}}, x_q[2*W-1:W]} * C_X) + {{W{1'b0}}, x_q[W-1:0]};

    // When x >= Q, the difference x - Q is below Q < 2^W, so the low W bits
    // of the subtraction are exact.
    logic            x_ge_q;
    logic [W-1:0]    x_minus_q;
    assign x_ge_q    = (x_q >= Q_X);
    assign x_minus_q = x_q[W-1:0] - Q_W;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = 1'b0;
        out_p_d     = out_p_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mul_a_d     = in_a;
                    mul_b_d     = in_b;
                    cnt_d       = '0;
                    mul_start_d = 1'b1;
                    state_d     = S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == LAT_CNT) begin
                    x_d     = mul_p;
                    state_d = S_FOLD1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FOLD1: begin
                x_d     = fold_v;
                state_d = S_FOLD2;
            end
            S_FOLD2: begin
                x_d     = fold_v;
                state_d = S_CORR;
            end
            S_CORR: begin
                out_p_d = x_ge_q ? x_minus_q : x_q[W-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            out_p_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            out_p_q     <= out_p_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_p     = out_p_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_start = mul_start_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_km_modmul_ctrl.sv
module tb_km_modmul_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    localparam logic [63:0] Q = 64'd4294967291;

    // dut0: MUL_LAT=0 with a combinational km_b model
    logic        in_valid0, in_ready0, out_valid0, out_ready0, mul_start0, busy0;
    logic [31:0] in_a0, in_b0, out_p0, mul_a0, mul_b0;
    logic [63:0] mul_p0;
    logic [2:0]  st0;

    // dut3: MUL_LAT=3 with a 3-stage delayed km_b model
    logic        in_valid3, in_ready3, out_valid3, out_ready3, mul_start3, busy3;
    logic [31:0] in_a3, in_b3, out_p3, mul_a3, mul_b3;
    logic [63:0] mul_p3, s1, s2, s3;
    logic [2:0]  st3;

    assign mul_p0 = {32'b0, mul_a0} * {32'b0, mul_b0};

    always @(posedge clk) begin
        s1 <= {32'b0, mul_a3} * {32'b0, mul_b3};
        s2 <= s1;
        s3 <= s2;
    end
    assign mul_p3 = s3;

    km_modmul_ctrl #(.W(32), .C(5), .MUL_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_p(out_p0),
        .mul_a(mul_a0), .mul_b(mul_b0), .mul_start(mul_start0), .mul_p(mul_p0),
        .busy(busy0), .dbg_state(st0)
    );

    km_modmul_ctrl #(.W(32), .C(5), .MUL_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_a(in_a3), .in_b(in_b3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_p(out_p3),
        .mul_a(mul_a3), .mul_b(mul_b3), .mul_start(mul_start3), .mul_p(mul_p3),
        .busy(busy3), .dbg_state(st3)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] ref_mod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        p = p % Q;
        return p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge with dut0 idle and out_ready0 low.
    task automatic run_op0(input logic [31:0] a, input logic [31:0] b,
                           input int stall, input bit junk, input string tag);
        logic [31:0] exp;
        int lat;
        exp_q.push_back(ref_mod(a, b));
        chk({tag, " in_ready"}, {63'b0, in_ready0}, 64'd1);
        in_a0 = a; in_b0 = b; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_a0 = 32'hDEAD_BEEF; in_b0 = 32'h1234_5678;
        lat = 0;
        while (out_valid0 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        exp = exp_q.pop_front();
        chk({tag, " latency"}, 64'(lat), 64'd4);
        chk({tag, " out_p"}, {32'b0, out_p0}, {32'b0, exp});
        for (int i = 0; i < stall; i++) begin
            if (junk) begin
                in_valid0 = 1'b1; in_a0 = $urandom; in_b0 = $urandom;
            end
            @(posedge clk); #1;
            in_valid0 = 1'b0;
            chk({tag, " hold out_valid"}, {63'b0, out_valid0}, 64'd1);
            chk({tag, " hold out_p"}, {32'b0, out_p0}, {32'b0, exp});
            chk({tag, " hold in_ready"}, {63'b0, in_ready0}, 64'd0);
        end
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
        chk({tag, " out_valid drop"}, {63'b0, out_valid0}, 64'd0);
        chk({tag, " idle busy"}, {63'b0, busy0}, 64'd0);
    endtask

    task automatic run_op3(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int lat;
        int starts;
        exp_q.push_back(ref_mod(a, b));
        in_a3 = a; in_b3 = b; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0; in_a3 = 32'h0BAD_F00D; in_b3 = 32'h0;
        lat = 0;
        starts = 0;
        while (out_valid3 !== 1'b1 && lat < 40) begin
            if (mul_start3 === 1'b1) starts++;
            if (lat < 4) begin
                chk({tag, " mul_a stable"}, {32'b0, mul_a3}, {32'b0, a});
                chk({tag, " mul_b stable"}, {32'b0, mul_b3}, {32'b0, b});
            end
            @(posedge clk); #1;
            lat++;
        end
        exp = exp_q.pop_front();
        chk({tag, " mul_start pulses"}, 64'(starts), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'd7);
        chk({tag, " out_p"}, {32'b0, out_p3}, {32'b0, exp});
        out_ready3 = 1'b1;
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        chk({tag, " out_valid drop"}, {63'b0, out_valid3}, 64'd0);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, " state"},     {61'b0, st0},        64'd0);
        chk({tag, " out_valid"}, {63'b0, out_valid0}, 64'd0);
        chk({tag, " out_p"},     {32'b0, out_p0},     64'd0);
        chk({tag, " mul_a"},     {32'b0, mul_a0},     64'd0);
        chk({tag, " mul_b"},     {32'b0, mul_b0},     64'd0);
        chk({tag, " mul_start"}, {63'b0, mul_start0}, 64'd0);
        chk({tag, " busy"},      {63'b0, busy0},      64'd0);
        chk({tag, " in_ready"},  {63'b0, in_ready0},  64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0; in_a0 = '0; in_b0 = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; in_a3 = '0; in_b3 = '0;
        #12;
        chk_reset0("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // T1
        run_op0(32'd13333, 32'd2972, 0, 1'b0, "T1");
        chk("T1 const", {32'b0, ref_mod(32'd13333, 32'd2972)}, 64'd39625676);

        // T2 / T3 boundary operands
        run_op0(32'd4294967290, 32'd4294967290, 0, 1'b0, "T2 qm1_sq");
        run_op0(32'd4294967295, 32'd2, 1, 1'b0, "T2 a_ge_q");
        run_op0(32'd1, 32'd4294967291, 0, 1'b0, "T3 a_times_q");
        run_op0(32'd0, 32'd987654321, 0, 1'b0, "T3 zero");
        run_op0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, "T3 max_sq");

        // T4 backpressure with ignored in_valid pulses
        run_op0(32'd123456789, 32'd3456789012, 10, 1'b1, "T4 bp");
        @(posedge clk); #1;
        chk("T4 no stray accept", {63'b0, busy0}, 64'd0);

        // T5 delayed multiplier
        run_op3(32'd123456789, 32'd987654321, "T5a");
        run_op3(32'd4294967290, 32'd4294967290, "T5b");
        run_op3(32'd13333, 32'd2972, "T5c");

        // T6 reset during FOLD1
        in_a0 = 32'd77777; in_b0 = 32'd88888; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(posedge clk); #1;
        chk("T6 in FOLD1", {61'b0, st0}, 64'd2);
        rst_n = 1'b0;
        #1;
        chk_reset0("T6 async");
        chk("T6 dut3 out_p", {32'b0, out_p3}, 64'd0);
        @(posedge clk); #1;
        chk("T6 held state", {61'b0, st0}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("T6 no result", {63'b0, out_valid0}, 64'd0);
        run_op0(32'd13333, 32'd2972, 0, 1'b0, "T6 fresh");

        // random pairs with stalls
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            run_op0($urandom, $urandom, $urandom_range(0, 3), 1'b1, "RND");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
